// File: rtl/led_share_arbiter.sv
// led_share_arbiter: round-robin sharing of an LED bank between requesters; the winner's
// pattern is latched and held for HOLD_T ticks of PRESCALE clocks.
module led_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int PRESCALE = 12000,
    parameter int HOLD_T   = 250
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] pat_i,
    output logic [N_REQ-1:0]        ack_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o,
    output logic [DATA_W-1:0]       led_o
);
    localparam int LW = $clog2(N_REQ);
    localparam int PW = $clog2(PRESCALE);
    localparam int HW = $clog2(HOLD_T) + 1;
    typedef enum logic {IDLE, SHOW} state_t;
    state_t state_q, state_d;
    logic [LW-1:0] last_q, last_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic [N_REQ-1:0] grant_q, grant_d, ack_q, ack_d;
    logic busy_q, busy_d;
    logic found, tick, done, arb;
    logic [LW-1:0] win;
    logic [DATA_W-1:0] win_pat;
    int j;
    // Search starts just after the previous winner, so it has lowest priority.
    always_comb begin
        found = 1'b0;
        win = '0;
        win_pat = '0;
        j = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(last_q) + k) % N_REQ;
            if (!found && req_i[j]) begin
                found = 1'b1;
                win = LW'(j);
                win_pat = pat_i[j*DATA_W +: DATA_W];
            end
        end
    end
    assign tick = pre_q == '0;
    assign done = state_q == SHOW && tick && hold_q == '0;
    assign arb  = found && (state_q == IDLE || done);
    always_comb begin
        state_d = state_q;
        last_d = last_q;
        pre_d = pre_q;
        hold_d = hold_q;
        led_d = led_q;
        grant_d = grant_q;
        busy_d = busy_q;
        ack_d = '0;
        if (state_q == SHOW) begin
            pre_d = tick ? PW'(PRESCALE - 1) : pre_q - 1'b1;
            hold_d = (tick && hold_q != '0) ? hold_q - 1'b1 : hold_q;
        end
        if (done) begin
            state_d = IDLE;
            led_d = '0;
            grant_d = '0;
            busy_d = 1'b0;
        end
        // A grant ending with requests pending hands over on the same edge.
        if (arb) begin
            state_d = SHOW;
            last_d = win;
            pre_d = PW'(PRESCALE - 1);
            hold_d = HW'(HOLD_T - 1);
            led_d = win_pat;
            grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win;
            ack_d = {{(N_REQ-1){1'b0}}, 1'b1} << win;
            busy_d = 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q <= LW'(N_REQ - 1);
            pre_q <= '0;
            hold_q <= '0;
            led_q <= '0;
            grant_q <= '0;
            ack_q <= '0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            pre_q <= pre_d;
            hold_q <= hold_d;
            led_q <= led_d;
            grant_q <= grant_d;
            ack_q <= ack_d;
            busy_q <= busy_d;
        end
    end
    assign ack_o = ack_q;
    assign grant_o = grant_q;
    assign busy_o = busy_q;
    assign led_o = led_q;
endmodule
